vram_arbiter: RTL and testbench

- Parametrised successor to the two-master VRAM lock mux in the graphics controller.
- Arbitrates N_PORTS masters (GPU, memory controller, future DMA/scanout) onto one synchronous single-port VRAM.
- Grants are round-robin with a registered request/grant handshake, an optional hold lock, and a hold-timeout that forces fairness.
- Read data returns one cycle after issue and is tagged per port, so a master never samples another master's data.

---
 rtl/gfx_pkg.sv | 16 +
 rtl/vram_sp.sv | 31 +++
 rtl/vram_arbiter.sv | 150 +++++++++++++++
 tb/tb_vram_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
// Shared graphics-controller definitions: VRAM geometry,
// arbiter state encoding and fixed master indices.
package gfx_pkg;

    localparam int VRAM_ADDR_W = 11;
    localparam int VRAM_DATA_W = 16;

    localparam int PORT_GPU  = 0;
    localparam int PORT_MEMC = 1;

    typedef enum logic {
        ARB_IDLE,
        ARB_OWNED
    } arb_state_t;

endpackage

// File: rtl/vram_sp.sv
// Synchronous single-port VRAM with registered read,
// write-first on a write cycle. Contents are never cleared.
module vram_sp #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
                r_rdata       <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/vram_arbiter.sv
// Round-robin N-master arbiter onto one single-port VRAM, with
// per-owner hold lock, contention timeout and port-tagged read data.
module vram_arbiter
    import gfx_pkg::*;
#(
    parameter int N_PORTS  = 2,
    parameter int ADDR_W   = VRAM_ADDR_W,
    parameter int DATA_W   = VRAM_DATA_W,
    parameter int MAX_HOLD = 64
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [N_PORTS-1:0]        REQ,
    input  logic [N_PORTS-1:0]        LOCK,
    input  logic [N_PORTS-1:0]        EN,
    input  logic [N_PORTS-1:0]        WE,
    input  logic [N_PORTS*ADDR_W-1:0] ADDR,
    input  logic [N_PORTS*DATA_W-1:0] WDATA,
    output logic [N_PORTS-1:0]        GNT,
    output logic [DATA_W-1:0]         RDATA,
    output logic [N_PORTS-1:0]        RVALID,
    output logic                      BUSY
);

    localparam int IDX_W = $clog2(N_PORTS);
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_PORTS - 1);

    // First requester strictly after 'last', wrapping; 'last' itself is lowest.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [N_PORTS-1:0] req,
        input logic [IDX_W-1:0]   last
    );
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] idx;
        pick = last;
        for (int k = N_PORTS; k >= 1; k--) begin
            idx = IDX_W'((int'(last) + k) % N_PORTS);
            if (req[idx]) pick = idx;
        end
        return pick;
    endfunction

    function automatic logic [N_PORTS-1:0] onehot(input logic [IDX_W-1:0] i);
        return N_PORTS'(1) << i;
    endfunction

    arb_state_t         r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_owner, w_owner_nxt;
    logic [IDX_W-1:0]   r_last, w_last_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [N_PORTS-1:0] r_gnt, w_gnt_nxt;
    logic [N_PORTS-1:0] r_rvalid;
    logic [N_PORTS-1:0] w_others;
    logic               w_contend, w_lock, w_oreq;
    logic               w_en, w_we;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_wdata;

    assign w_others  = REQ & ~r_gnt;
    assign w_contend = |w_others;
    assign w_lock    = LOCK[r_owner];
    assign w_oreq    = REQ[r_owner];
    assign w_cnt_inc = (w_contend && r_cnt != HOLD_MAX) ? r_cnt + 1'b1 : r_cnt;

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_gnt_nxt   = r_gnt;
        unique case (r_state)
            ARB_IDLE: begin
                if (|REQ) begin
                    w_owner_nxt = rr_pick(REQ, r_last);
                    w_gnt_nxt   = onehot(w_owner_nxt);
                    w_state_nxt = ARB_OWNED;
                    w_cnt_nxt   = '0;
                end
            end
            ARB_OWNED: begin
                if (w_lock) begin
                    w_cnt_nxt = '0;
                end else if (!w_oreq || w_cnt_inc == HOLD_MAX) begin
                    w_last_nxt = r_owner;
                    w_cnt_nxt  = '0;
                    if (w_contend) begin
                        w_owner_nxt = rr_pick(w_others, r_owner);
                        w_gnt_nxt   = onehot(w_owner_nxt);
                    end else begin
                        w_state_nxt = ARB_IDLE;
                        w_gnt_nxt   = '0;
                    end
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= ARB_IDLE;
            r_owner <= '0;
            r_last  <= LAST_RST;
            r_cnt   <= '0;
            r_gnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gnt   <= w_gnt_nxt;
        end
    end

    // Access mux follows the pre-edge owner, so a release-edge access still lands.
    assign w_en    = (r_state == ARB_OWNED) && EN[r_owner];
    assign w_we    = WE[r_owner];
    assign w_addr  = ADDR[int'(r_owner)*ADDR_W +: ADDR_W];
    assign w_wdata = WDATA[int'(r_owner)*DATA_W +: DATA_W];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_rvalid <= '0;
        end else if (w_en && !w_we) begin
            r_rvalid <= onehot(r_owner);
        end else begin
            r_rvalid <= '0;
        end
    end

    vram_sp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_vram (
        .i_clk   (CLK),
        .i_en    (w_en),
        .i_we    (w_we),
        .i_addr  (w_addr),
        .i_wdata (w_wdata),
        .o_rdata (RDATA)
    );

    assign GNT    = r_gnt;
    assign RVALID = r_rvalid;
    assign BUSY   = |r_gnt;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus random traffic
// checked every cycle against a transaction-level arbitration model.
module tb_vram_arbiter;

    localparam int N  = 4;
    localparam int AW = 11;
    localparam int DW = 16;
    localparam int MH = 4;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [N-1:0]  REQ, LOCK, EN, WE;
    logic [N*AW-1:0] ADDR;
    logic [N*DW-1:0] WDATA;
    logic [N-1:0]  GNT, RVALID;
    logic [DW-1:0] RDATA;
    logic          BUSY;

    vram_arbiter #(
        .N_PORTS  (N),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_HOLD (MH)
    ) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .REQ    (REQ),
        .LOCK   (LOCK),
        .EN     (EN),
        .WE     (WE),
        .ADDR   (ADDR),
        .WDATA  (WDATA),
        .GNT    (GNT),
        .RDATA  (RDATA),
        .RVALID (RVALID),
        .BUSY   (BUSY)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model: owner index (-1 idle), last owner, contended cycles this tenure.
    int            m_own, m_last, m_hold;
    logic [N-1:0]  m_rv;
    logic [DW-1:0] m_rd;
    bit            m_rdk;
    logic [DW-1:0] m_mem [2**AW];
    bit            m_known [2**AW];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit bit_of(input logic [N-1:0] v, input int i);
        logic [N-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic int next_after(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++)
            if (bit_of(r, (last + k) % N)) return (last + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_gnt();
        return (m_own < 0) ? '0 : (N'(1) << m_own);
    endfunction

    task automatic model_reset();
        m_own  = -1;
        m_last = N - 1;
        m_hold = 0;
        m_rv   = '0;
        m_rdk  = 1'b0;
    endtask

    task automatic model_step();
        logic [AW-1:0] av;
        logic [DW-1:0] dv;
        logic [N-1:0]  others;
        if (RESET) begin
            model_reset();
            return;
        end
        m_rv = '0;
        if (m_own >= 0 && bit_of(EN, m_own)) begin
            av = AW'(ADDR >> (m_own * AW));
            dv = DW'(WDATA >> (m_own * DW));
            if (bit_of(WE, m_own)) begin
                m_mem[av]   = dv;
                m_known[av] = 1'b1;
            end else begin
                m_rv  = N'(1) << m_own;
                m_rd  = m_mem[av];
                m_rdk = m_known[av];
            end
        end
        if (m_own < 0) begin
            if (REQ != '0) begin
                m_own  = next_after(REQ, m_last);
                m_hold = 0;
            end
        end else begin
            others = REQ & ~(N'(1) << m_own);
            if (bit_of(LOCK, m_own)) begin
                m_hold = 0;
            end else begin
                if (others != '0 && m_hold < MH) m_hold++;
                if (!bit_of(REQ, m_own) || m_hold == MH) begin
                    m_last = m_own;
                    m_own  = (others != '0) ? next_after(others, m_own) : -1;
                    m_hold = 0;
                end
            end
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            check("gnt", 32'(GNT), 32'(exp_gnt()));
            check("busy", 32'(BUSY), 32'(m_own >= 0));
            check("rvalid", 32'(RVALID), 32'(m_rv));
            if (m_rv != '0 && m_rdk)
                check("rdata", 32'(RDATA), 32'(m_rd));
        end
    end

    task automatic tick();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
    endtask

    task automatic drive(input int i, input bit en, input bit we,
                         input int a, input int d);
        EN[i] = en;
        WE[i] = we;
        ADDR[i*AW +: AW]  = AW'(a);
        WDATA[i*DW +: DW] = DW'(d);
    endtask

    initial begin
        RESET = 1'b1;
        REQ = '0; LOCK = '0; EN = '0; WE = '0; ADDR = '0; WDATA = '0;
        for (int i = 0; i < 2**AW; i++) m_known[i] = 1'b0;
        model_reset();
        tick();
        tick();
        check("reset_gnt", 32'(GNT), 32'h0);
        check("reset_rvalid", 32'(RVALID), 32'h0);
        check("reset_busy", 32'(BUSY), 32'h0);
        RESET  = 1'b0;
        chk_en = 1'b1;

        // single port grant, write then read back
        REQ = 4'b0001;
        tick();
        check("single_gnt", 32'(GNT), 32'h1);
        drive(0, 1, 1, 'h123, 'hBEEF);
        tick();
        drive(0, 1, 0, 'h123, 0);
        tick();
        check("single_rvalid", 32'(RVALID), 32'h1);
        check("single_rdata", 32'(RDATA), 32'hBEEF);

        // isolation: non-owner write must not land
        drive(0, 1, 1, 'h005, 'h1111);
        tick();
        drive(0, 1, 1, 'h010, 'h2222);
        tick();
        drive(0, 0, 0, 0, 0);
        drive(1, 1, 1, 'h005, 'hDEAD);
        tick();
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 'h005, 0);
        tick();
        check("iso_rdata", 32'(RDATA), 32'h1111);

        // tagging: read on the release edge returns to port 0
        drive(0, 0, 0, 0, 0);
        REQ = 4'b0011;
        tick();
        REQ = 4'b0010;
        drive(0, 1, 0, 'h010, 0);
        tick();
        check("tag_gnt", 32'(GNT), 32'h2);
        check("tag_rvalid", 32'(RVALID), 32'h1);
        check("tag_rdata", 32'(RDATA), 32'h2222);

        // reset mid-grant with a read in flight
        drive(0, 0, 0, 0, 0);
        drive(1, 1, 0, 'h123, 0);
        tick();
        check("pre_rst_rvalid", 32'(RVALID), 32'h2);
        drive(1, 0, 0, 0, 0);
        #1 RESET = 1'b1;
        model_reset();
        #1;
        check("async_rst_gnt", 32'(GNT), 32'h0);
        check("async_rst_rvalid", 32'(RVALID), 32'h0);
        tick();
        RESET = 1'b0;
        REQ = 4'b0011;
        tick();
        check("post_rst_gnt", 32'(GNT), 32'h1);

        // lock holds ownership far beyond the timeout
        LOCK = 4'b0001;
        repeat (200) tick();
        check("lock_gnt", 32'(GNT), 32'h1);
        LOCK = '0;
        REQ  = 4'b0010;
        tick();
        check("unlock_gnt", 32'(GNT), 32'h2);

        // fairness: everyone requesting, each owner keeps MH cycles
        REQ = 4'b1111;
        for (int k = 0; k < 5 * MH; k++) begin
            check("fair_gnt", 32'(GNT), 32'(N'(1) << ((1 + k / MH) % N)));
            tick();
        end

        // random traffic
        REQ = '0;
        tick();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (m_own == i) begin
                    LOCK[i] = ($urandom_range(0, 7) == 0);
                    if ($urandom_range(0, 5) == 0) REQ[i] = 1'b0;
                end else begin
                    LOCK[i] = $urandom_range(0, 1) == 1;
                    if (!REQ[i] && $urandom_range(0, 3) == 0) REQ[i] = 1'b1;
                end
                drive(i, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 15), $urandom_range(0, 65535));
            end
            tick();
        end
        REQ = '0; LOCK = '0; EN = '0;
        repeat (4) tick();
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
